un_striping_sched: RTL and testbench

- Scheduler that merges two 32-bit striped lanes back into a single word stream, in strict lane order 0,1,0,1,...
- Sits between the two lane receivers and the un-striped output path, all on clk_2f.
- Buffers each lane in a small FIFO, so lane skew up to DEPTH words is absorbed.
- Detects lane-order/skew faults and FIFO overflow, and counts merged words.

---
 rtl/un_striping_sched.sv | 170 +++++++++++++++++
 tb/tb_un_striping_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/un_striping_sched.sv
// Two-lane un-striping scheduler: per-lane FIFOs merged in strict 0,1,0,1 order,
// with skew timeout, overflow detection and a delivered-word counter.

module un_striping_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk_2f,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk_2f) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_2f) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Pop reads the head combinationally; a same-cycle push to a full FIFO
    // overwrites that slot only at the edge, after the head has been taken.
    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
endmodule

module un_striping_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             valid_0,
    input  logic [31:0]      lane_0,
    input  logic             valid_1,
    input  logic [31:0]      lane_1,
    input  logic             out_ready,
    output logic             valid_out,
    output logic [31:0]      data_out,
    output logic             skew_err,
    output logic             ovf_err,
    output logic [CNT_W-1:0] word_count
);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EXP0, EXP1, ERR} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   stall, stall_nx;
    logic            flush, inc;
    logic [1:0]      lane_vld, push, pop, empty, full, ovf;
    logic [1:0][31:0] lane_din, lane_dout;

    assign lane_vld = {valid_1, valid_0};
    assign lane_din = {lane_1, lane_0};

    for (genvar k = 0; k < 2; k++) begin : g_lane
        // A full FIFO still accepts when it is popped in the same cycle.
        assign push[k] = lane_vld[k] && !flush && (!full[k] || pop[k]);
        assign ovf[k]  = lane_vld[k] && !flush && full[k] && !pop[k];

        un_striping_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
            .clk_2f (clk_2f),
            .reset  (reset),
            .flush  (flush),
            .push   (push[k]),
            .pop    (pop[k]),
            .din    (lane_din[k]),
            .dout   (lane_dout[k]),
            .empty  (empty[k]),
            .full   (full[k])
        );
    end

    always_comb begin
        state_nx = state;
        stall_nx = stall;
        pop      = '0;
        flush    = 1'b0;
        inc      = 1'b0;
        case (state)
            IDLE, EXP0: if (out_ready) begin
                if (!empty[0]) begin
                    pop[0]   = 1'b1;
                    state_nx = EXP1;
                    stall_nx = '0;
                end else if (!empty[1]) begin
                    inc = 1'b1;
                end else begin
                    stall_nx = '0;
                    state_nx = IDLE;
                end
            end
            EXP1: if (out_ready) begin
                if (!empty[1]) begin
                    pop[1]   = 1'b1;
                    state_nx = EXP0;
                    stall_nx = '0;
                end else if (!empty[0]) begin
                    inc = 1'b1;
                end else begin
                    stall_nx = '0;
                end
            end
            ERR: begin
                flush    = 1'b1;
                stall_nx = '0;
                state_nx = IDLE;
            end
        endcase
        // Only the wrong lane waiting counts as skew; an empty pair is just idle.
        if (inc) begin
            stall_nx = stall + SW'(1);
            if (stall_nx == SW'(TIMEOUT)) state_nx = ERR;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state      <= IDLE;
            stall      <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            skew_err   <= 1'b0;
            ovf_err    <= 1'b0;
            word_count <= '0;
        end else begin
            state <= state_nx;
            stall <= stall_nx;
            if (state == ERR) begin
                skew_err  <= 1'b1;
                valid_out <= 1'b0;
            end else if (out_ready) begin
                if (|pop) begin
                    valid_out  <= 1'b1;
                    data_out   <= pop[0] ? lane_dout[0] : lane_dout[1];
                    word_count <= word_count + CNT_W'(1);
                end else begin
                    valid_out <= 1'b0;
                end
            end
            if (|ovf) ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_un_striping_sched.sv
// Self-checking bench for un_striping_sched: directed scenarios plus a
// randomized run against a queue-based model of the lane-merge rules.

module tb_un_striping_sched;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    logic             clk_2f = 1'b0;
    logic             reset, valid_0, valid_1, out_ready;
    logic [31:0]      lane_0, lane_1;
    logic             valid_out, skew_err, ovf_err;
    logic [31:0]      data_out;
    logic [CNT_W-1:0] word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk_2f = ~clk_2f;

    un_striping_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .valid_0    (valid_0),
        .lane_0     (lane_0),
        .valid_1    (valid_1),
        .lane_1     (lane_1),
        .out_ready  (out_ready),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .skew_err   (skew_err),
        .ovf_err    (ovf_err),
        .word_count (word_count)
    );

    // Reference model: one queue per lane and the lane that must come next.
    logic [31:0]      mq0[$], mq1[$];
    int               m_next, m_stall;
    bit               m_err, m_vo, m_skew, m_ovf;
    logic [31:0]      m_do;
    logic [CNT_W-1:0] m_cnt;

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle_in();
        valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; out_ready = 1'b1; idle_in();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic model_step();
        bit          flushed = 0;
        int          got = -1;
        logic [31:0] w = '0;
        if (reset) begin
            mq0.delete(); mq1.delete();
            m_next = 0; m_stall = 0; m_err = 0; m_vo = 0; m_do = '0;
            m_skew = 0; m_ovf = 0; m_cnt = '0;
            return;
        end
        if (m_err) begin
            flushed = 1; mq0.delete(); mq1.delete();
            m_err = 0; m_next = 0; m_stall = 0; m_skew = 1; m_vo = 0;
        end else if (out_ready) begin
            if (m_next == 0 && mq0.size() > 0) begin got = 0; w = mq0.pop_front(); end
            else if (m_next == 1 && mq1.size() > 0) begin got = 1; w = mq1.pop_front(); end
            else if ((m_next == 0 ? mq1.size() : mq0.size()) > 0) begin
                m_stall++;
                if (m_stall == TIMEOUT) m_err = 1;
            end else begin
                m_stall = 0;
            end
            if (got >= 0) begin
                m_stall = 0; m_next = 1 - got; m_vo = 1; m_do = w; m_cnt++;
            end else begin
                m_vo = 0;
            end
        end
        if (!flushed) begin
            if (valid_0) begin if (mq0.size() < DEPTH) mq0.push_back(lane_0); else m_ovf = 1; end
            if (valid_1) begin if (mq1.size() < DEPTH) mq1.push_back(lane_1); else m_ovf = 1; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0; idle_in();
        tick(); tick();
        reset = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %0b want 0", valid_out); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL reset_skew_err got %0b want 0", skew_err); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err got %0b want 0", ovf_err); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    endtask

    task automatic test_aligned();
        logic [31:0] w [4];
        w = '{32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'hCCCC_CCCC};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle_in();
            if (i < 4) begin
                if (i % 2 == 0) begin valid_0 = 1'b1; lane_0 = w[i]; end
                else begin valid_1 = 1'b1; lane_1 = w[i]; end
            end
            tick();
            if (i == 0) begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL aligned_first_latency valid_out got %0b want 0", valid_out); end
            end else begin
                checks++;
                if (valid_out !== 1'b1 || data_out !== w[i-1]) begin
                    errors++; $display("FAIL aligned_word%0d got v=%0b %h want v=1 %h", i-1, valid_out, data_out, w[i-1]);
                end
            end
        end
        idle_in(); tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL aligned_end valid_out got %0b want 0", valid_out); end
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL aligned_count got %0d want 4", word_count); end
        checks++; if (skew_err !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL aligned_errs got skew=%0b ovf=%0b want 0 0", skew_err, ovf_err); end
    endtask

    task automatic test_skew();
        logic [31:0] got[$];
        logic [31:0] exp_w [4];
        exp_w = '{32'hAAAA_AAAA, 32'h9999_9999, 32'h0000_0007, 32'h0000_0008};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            idle_in();
            case (c)
                0: begin valid_0 = 1'b1; lane_0 = 32'hAAAA_AAAA; end
                1: begin valid_0 = 1'b1; lane_0 = 32'h0000_0007; end
                3: begin valid_1 = 1'b1; lane_1 = 32'h9999_9999; end
                4: begin valid_1 = 1'b1; lane_1 = 32'h0000_0008; end
                default: ;
            endcase
            tick();
            if (valid_out) got.push_back(data_out);
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL skew_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL skew_order[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL skew_err got %0b want 0", skew_err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        do_reset();
        for (int c = 0; c < 10; c++) begin
            idle_in();
            out_ready = !(c >= 2 && c <= 4);
            case (c)
                0: begin valid_0 = 1'b1; lane_0 = 32'h1111_0000; end
                1: begin valid_1 = 1'b1; lane_1 = 32'h1111_0001; end
                2: begin valid_0 = 1'b1; lane_0 = 32'h1111_0002; end
                3: begin valid_1 = 1'b1; lane_1 = 32'h1111_0003; end
                default: ;
            endcase
            tick();
            if (c >= 2 && c <= 4) begin
                checks++;
                if (valid_out !== 1'b1 || data_out !== 32'h1111_0000 || word_count !== 16'd1) begin
                    errors++; $display("FAIL bp_hold c%0d got v=%0b %h cnt=%0d want v=1 11110000 cnt=1", c, valid_out, data_out, word_count);
                end
            end
            if (out_ready && valid_out) got.push_back(data_out);
        end
        out_ready = 1'b1;
        checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== 32'h1111_0000 + i) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], 32'h1111_0000 + i); end
        end
    endtask

    task automatic test_orphan();
        bit saw_valid = 0;
        logic [31:0] got[$];
        do_reset();
        valid_1 = 1'b1; lane_1 = 32'h2222_2222;
        tick();
        idle_in();
        for (int t = 2; t <= 10; t++) begin
            tick();
            if (valid_out) saw_valid = 1;
            if (t == 9) begin
                checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL orphan_early skew_err got %0b want 0", skew_err); end
            end
        end
        checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL orphan_timeout skew_err got %0b want 1", skew_err); end
        checks++; if (saw_valid) begin errors++; $display("FAIL orphan_no_output got valid_out=1 want 0"); end
        for (int c = 0; c < 4; c++) begin
            idle_in();
            if (c == 0) begin valid_0 = 1'b1; lane_0 = 32'h3333_3333; end
            if (c == 1) begin valid_1 = 1'b1; lane_1 = 32'h4444_4444; end
            tick();
            if (valid_out) got.push_back(data_out);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h3333_3333 || got[1] !== 32'h4444_4444) begin
            errors++; $display("FAIL orphan_recover got %0d words first=%h want 2 words 33333333 44444444", got.size(), (got.size() > 0) ? got[0] : 32'h0);
        end
        checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky skew_err got %0b want 1", skew_err); end
    endtask

    task automatic test_overflow_reset();
        logic [31:0] got[$];
        bit          saw_valid = 0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle_in();
            valid_0 = 1'b1; lane_0 = 32'h5000_0000 + i;
            if (i < 4) begin valid_1 = 1'b1; lane_1 = 32'h6000_0000 + i; end
            tick();
            if (i == 3) begin
                checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", ovf_err); end
            end
        end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", ovf_err); end
        idle_in(); out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (valid_out) got.push_back(data_out);
        end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL ovf_delivered got %0d want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            logic [31:0] e;
            e = (i % 2 == 0) ? 32'h5000_0000 + i/2 : 32'h6000_0000 + i/2;
            checks++; if (got[i] !== e) begin errors++; $display("FAIL ovf_order[%0d] got %h want %h", i, got[i], e); end
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_0 = 1'b1; lane_0 = 32'h7000_0000 + i;
            valid_1 = 1'b1; lane_1 = 32'h8000_0000 + i;
            tick();
        end
        idle_in(); out_ready = 1'b1;
        tick(); tick();
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h8000_0000) begin errors++; $display("FAIL mid_delivery got v=%0b %h want v=1 80000000", valid_out, data_out); end
        reset = 1'b1;
        tick();
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'h0 || skew_err !== 1'b0 || ovf_err !== 1'b0 || word_count !== '0) begin
            errors++; $display("FAIL mid_reset got v=%0b d=%h skew=%0b ovf=%0b cnt=%0d want all 0", valid_out, data_out, skew_err, ovf_err, word_count);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid_out) saw_valid = 1;
        end
        checks++; if (saw_valid || word_count !== '0) begin errors++; $display("FAIL stale_after_reset got valid=%0b cnt=%0d want 0 0", saw_valid, word_count); end
    endtask

    task automatic test_random();
        bit turn = 0;
        int mode;
        for (int c = 0; c < 3000; c++) begin
            mode = (c / 250) % 3;
            reset = (c < 2) || ($urandom_range(0, 399) == 0);
            idle_in();
            lane_0 = $urandom; lane_1 = $urandom;
            case (mode)
                0: begin
                    valid_0 = ($urandom_range(0, 99) < 40);
                    valid_1 = ($urandom_range(0, 99) < 40);
                    out_ready = ($urandom_range(0, 99) < 80);
                end
                1: begin
                    if ($urandom_range(0, 99) < 80) begin
                        if (turn) valid_1 = 1'b1; else valid_0 = 1'b1;
                        turn = ~turn;
                    end
                    out_ready = ($urandom_range(0, 99) < 85);
                end
                default: begin
                    valid_0 = ($urandom_range(0, 99) < 70);
                    valid_1 = ($urandom_range(0, 99) < 70);
                    out_ready = ($urandom_range(0, 99) < 50);
                end
            endcase
            model_step();
            tick();
            checks++; if (valid_out !== m_vo) begin errors++; $display("FAIL rand_valid c%0d got %0b want %0b", c, valid_out, m_vo); end
            checks++; if (data_out !== m_do) begin errors++; $display("FAIL rand_data c%0d got %h want %h", c, data_out, m_do); end
            checks++; if (word_count !== m_cnt) begin errors++; $display("FAIL rand_count c%0d got %0d want %0d", c, word_count, m_cnt); end
            checks++; if (skew_err !== m_skew) begin errors++; $display("FAIL rand_skew c%0d got %0b want %0b", c, skew_err, m_skew); end
            checks++; if (ovf_err !== m_ovf) begin errors++; $display("FAIL rand_ovf c%0d got %0b want %0b", c, ovf_err, m_ovf); end
        end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0; idle_in();
        test_reset();
        test_aligned();
        test_skew();
        test_backpressure();
        test_orphan();
        test_overflow_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
